reg_status_file: RTL

- Architectural register file with per-register rename status (busy bit and producing ROB tag).
- Sits at the receiving end of the ROB commit bus:
  - consumes commit-enable / ROB number / rd / value;
  - consumes the flush pulse;
  - takes rename requests from the issue stage.
- Serves two source-operand lookups to issue. Each lookup returns either a ready value or the ROB tag to wait on.

---
 rtl/reg_status_file.sv | 126 ++++++++++++
 1 files changed

// File: rtl/reg_status_file.sv
// reg_status_file
// Architectural register file with per-register rename status. Each
// register holds a committed value, a busy bit and the ROB tag of the
// in-flight instruction that will produce its next value. Commits from
// the ROB write values and release busy bits; renames from issue mark
// registers busy; a flush releases every busy bit at once. Two
// combinational lookups give issue either a ready operand or the tag
// to wait on, with a bypass for the value being committed this cycle.

module reg_status_file #(
   parameter int REG_NUM    = 32,
   parameter int REG_ADDR_W = 5,
   parameter int XLEN       = 32
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  rdy_in,
   input  logic                  clear_in,
   input  logic                  commit_en_in,
   input  logic [REG_ADDR_W-1:0] commit_rob_in,
   input  logic [REG_ADDR_W-1:0] commit_rd_in,
   input  logic [XLEN-1:0]       commit_val_in,
   input  logic                  rename_en_in,
   input  logic [REG_ADDR_W-1:0] rename_rd_in,
   input  logic [REG_ADDR_W-1:0] rename_rob_in,
   input  logic [REG_ADDR_W-1:0] rs1_in,
   input  logic [REG_ADDR_W-1:0] rs2_in,
   output logic                  rs1_busy_out,
   output logic [XLEN-1:0]       rs1_val_out,
   output logic [REG_ADDR_W-1:0] rs1_tag_out,
   output logic                  rs2_busy_out,
   output logic [XLEN-1:0]       rs2_val_out,
   output logic [REG_ADDR_W-1:0] rs2_tag_out,
   output logic [XLEN-1:0]       retire_cnt_out
);

   logic [XLEN-1:0]       value_q [REG_NUM];
   logic                  busy_q  [REG_NUM];
   logic [REG_ADDR_W-1:0] tag_q   [REG_NUM];
   logic [XLEN-1:0]       retire_cnt_q;

   logic commit_go;
   logic rename_go;

   // Qualify commit and rename with the global ready; a flush suppresses rename
   always_comb begin
      commit_go = rdy_in & commit_en_in;
      rename_go = rdy_in & rename_en_in & ~clear_in & (rename_rd_in != '0);
   end

   // Register table update: commit writes values, rename claims busy/tag,
   // a matching commit releases busy, a flush releases every register.
   // Entry 0 is never touched so x0 stays zero and never busy.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int i = 0; i < REG_NUM; i++) begin
            value_q[i] <= '0;
            busy_q[i]  <= 1'b0;
            tag_q[i]   <= '0;
         end
      end else if (rdy_in) begin
         for (int i = 1; i < REG_NUM; i++) begin
            if (commit_go && commit_rd_in == REG_ADDR_W'(i)) begin
               value_q[i] <= commit_val_in;
            end
            if (clear_in) begin
               busy_q[i] <= 1'b0;
            end else if (rename_go && rename_rd_in == REG_ADDR_W'(i)) begin
               busy_q[i] <= 1'b1;
               tag_q[i]  <= rename_rob_in;
            end else if (commit_go && commit_rd_in == REG_ADDR_W'(i) &&
                         busy_q[i] && tag_q[i] == commit_rob_in) begin
               busy_q[i] <= 1'b0;
            end
         end
      end
   end

   // Retired-instruction counter; counts every commit including rd=x0
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         retire_cnt_q <= '0;
      end else if (commit_go) begin
         retire_cnt_q <= retire_cnt_q + XLEN'(1);
      end
   end

   assign retire_cnt_out = retire_cnt_q;

   // Source 1 lookup, bypassing the value the ROB is committing right now
   always_comb begin
      rs1_busy_out = 1'b0;
      rs1_val_out  = '0;
      rs1_tag_out  = '0;
      if (rs1_in != '0) begin
         rs1_tag_out = tag_q[rs1_in];
         if (commit_go && commit_rd_in == rs1_in &&
             busy_q[rs1_in] && tag_q[rs1_in] == commit_rob_in) begin
            rs1_busy_out = 1'b0;
            rs1_val_out  = commit_val_in;
         end else begin
            rs1_busy_out = busy_q[rs1_in];
            rs1_val_out  = value_q[rs1_in];
         end
      end
   end

   // Source 2 lookup, same rules as source 1
   always_comb begin
      rs2_busy_out = 1'b0;
      rs2_val_out  = '0;
      rs2_tag_out  = '0;
      if (rs2_in != '0) begin
         rs2_tag_out = tag_q[rs2_in];
         if (commit_go && commit_rd_in == rs2_in &&
             busy_q[rs2_in] && tag_q[rs2_in] == commit_rob_in) begin
            rs2_busy_out = 1'b0;
            rs2_val_out  = commit_val_in;
         end else begin
            rs2_busy_out = busy_q[rs2_in];
            rs2_val_out  = value_q[rs2_in];
         end
      end
   end

endmodule
